// File: rtl/mult_seq_32.sv
// mult_seq_32: sequential 32x32 unsigned shift-and-add multiplier.
// One add-and-shift iteration per clock. Partial sums are formed by adder_32bit.
// Optional build macro MULT_EARLY_TERM_EN ends the run once every remaining
// multiplier bit is zero. The result is then realigned by a barrel shift.

// adder_32bit: 32-bit adder built from 4-bit carry-lookahead groups.
// Carries ripple between the groups.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] s,
    output logic        c
);
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GROUPS = WIDTH / 4;

    logic [WIDTH-1:0]  gen_c;
    logic [WIDTH-1:0]  prop_c;
    logic [WIDTH-1:0]  bit_carry_c;
    logic [GROUPS:0]   grp_carry_c;
    logic [GROUPS-1:0] grp_gen_c;
    logic [GROUPS-1:0] grp_prop_c;

    // Per-bit generate/propagate.
    always_comb begin
        gen_c  = a & b;
        prop_c = a ^ b;
    end

    // Group lookahead terms, the carry chain between groups, and the ripple inside each group.
    always_comb begin
        grp_carry_c    = '0;
        grp_gen_c      = '0;
        grp_prop_c     = '0;
        bit_carry_c    = '0;
        grp_carry_c[0] = c0;
        for (int j = 0; j < int'(GROUPS); j++) begin
            grp_prop_c[j] = &prop_c[4*j +: 4];
            grp_gen_c[j]  = gen_c[4*j+3]
                          | (prop_c[4*j+3] & gen_c[4*j+2])
                          | (prop_c[4*j+3] & prop_c[4*j+2] & gen_c[4*j+1])
                          | (prop_c[4*j+3] & prop_c[4*j+2] & prop_c[4*j+1] & gen_c[4*j]);
            grp_carry_c[j+1] = grp_gen_c[j] | (grp_prop_c[j] & grp_carry_c[j]);
            bit_carry_c[4*j] = grp_carry_c[j];
            for (int i = 1; i < 4; i++) begin
                bit_carry_c[4*j+i] = gen_c[4*j+i-1] | (prop_c[4*j+i-1] & bit_carry_c[4*j+i-1]);
            end
        end
    end

    // Sum and carry out.
    always_comb begin
        s = prop_c ^ bit_carry_c;
        c = grp_carry_c[GROUPS];
    end
endmodule

module mult_seq_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     mcand_q, mcand_d;
    // Bit 64 of the architectural P register always shifts in as zero, so it is not stored.
    logic [PROD_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [OP_W-1:0]     add_sum_c;
    logic                add_carry_c;
    logic [OP_W:0]       acc_next_c;
    logic [PROD_W-1:0]   p_next_c;
    logic [CNT_W-1:0]    cnt_next_c;
    logic                finish_c;
    logic [PROD_W-1:0]   result_c;

    // Partial-sum adder: accumulator plus multiplicand, with no carry in.
    adder_32bit u_adder (
        .a  (p_q[PROD_W-1:OP_W]),
        .b  (mcand_q),
        .c0 (1'b0),
        .s  (add_sum_c),
        .c  (add_carry_c)
    );

    // One iteration: conditionally add, then shift right. The carry out becomes the new accumulator MSB.
    always_comb begin
        acc_next_c = p_q[0] ? {add_carry_c, add_sum_c} : {1'b0, p_q[PROD_W-1:OP_W]};
        p_next_c   = {acc_next_c, p_q[OP_W-1:1]};
        cnt_next_c = cnt_q + CNT_W'(1);
    end

`ifdef MULT_EARLY_TERM_EN
    logic [OP_W-1:0]  live_mask_c;
    logic [CNT_W-1:0] remain_c;

    // Finish when the unconsumed multiplier bits are all zero. Then realign the result by the iterations skipped.
    always_comb begin
        live_mask_c = {OP_W{1'b1}} >> cnt_next_c;
        remain_c    = CNT_W'(OP_W) - cnt_next_c;
        finish_c    = ((p_next_c[OP_W-1:0] & live_mask_c) == '0);
        result_c    = p_next_c >> remain_c;
    end
`else
    // Always run the full 32 iterations. The result needs no realignment.
    always_comb begin
        finish_c = (cnt_next_c == CNT_W'(OP_W));
        result_c = p_next_c;
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mcand_d = a;
                    p_d     = {{(PROD_W-OP_W){1'b0}}, b};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d   = p_next_c;
                cnt_d = cnt_next_c;
                if (finish_c) begin
                    state_d   = ST_DONE;
                    product_d = result_c;
                    done_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        busy    = busy_q;
        done    = done_q;
        product = product_q;
    end
endmodule

// File: tb/tb_mult_seq_32.sv
// Directed bench for mult_seq_32. Expected latencies follow MULT_EARLY_TERM_EN when it is defined.
`timescale 1ns/1ps
module tb_mult_seq_32;
`ifdef MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_cmp = 0;
    int n_err = 0;

    mult_seq_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic accept(input logic [31:0] ta, input logic [31:0] tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
    endtask

    // Called in the cycle after the accept edge. Returns in the done cycle.
    task automatic wait_done(input string tag, input logic [63:0] exp_p, input int exp_lat);
        int lat = 41;
        int bc  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bc++;
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
        chk({tag, "_product"}, product, exp_p);
    endtask

    // One cycle after done: the pulse must be gone and the product must hold.
    task automatic after_done(input string tag, input logic [63:0] exp_p);
        tick();
        chk({tag, "_done_drop"}, 64'(done), 64'(0));
        chk({tag, "_product_hold"}, product, exp_p);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_product", product, 64'h0);
        rst_n = 1'b1;
        tick();

        // Basic 3*5: highest set bit of b is bit 2.
        accept(32'd3, 32'd5);
        chk("basic_busy_rise", 64'(busy), 64'(1));
        wait_done("basic", 64'h0F, ET ? 3 : 32);
        after_done("basic", 64'h0F);

        // Maximum operands always take 32 iterations.
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max", 64'hFFFF_FFFE_0000_0001, 32);
        after_done("max", 64'hFFFF_FFFE_0000_0001);

        // Start while busy is ignored: 7*9 = 63.
        accept(32'd7, 32'd9);
        dones = 0;
        repeat (ET ? 1 : 9) begin
            tick();
            if (done) dones++;
        end
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done) dones++;
        for (int i = 0; i < 40; i++) begin
            if (done) chk("ignore_product", product, 64'h3F);
            tick();
            if (done) dones++;
        end
        chk("ignore_done_count", 64'(dones), 64'(1));
        chk("ignore_product_final", product, 64'h3F);

        // Asynchronous reset mid-run, between edges.
        accept(32'h1234_5678, 32'h1234_5678);
        repeat (14) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_product", product, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'(0));
        accept(32'd2, 32'd2);
        wait_done("after_rst", 64'd4, ET ? 2 : 32);
        after_done("after_rst", 64'd4);

        // Zero multiplier.
        accept(32'hDEAD, 32'h0);
        wait_done("b_zero", 64'h0, ET ? 1 : 32);
        after_done("b_zero", 64'h0);

        // Only the top multiplier bit is set.
        accept(32'd2, 32'h8000_0000);
        wait_done("b_msb", 64'h1_0000_0000, 32);

        // Back-to-back start issued in the done cycle.
        accept(32'd10, 32'd10);
        chk("b2b_prior_product", product, 64'h1_0000_0000);
        chk("b2b_done_drop", 64'(done), 64'(0));
        chk("b2b_busy_rise", 64'(busy), 64'(1));
        wait_done("b2b", 64'd100, ET ? 4 : 32);
        after_done("b2b", 64'd100);

        // Random-width check on a mid-size product: 0x10001 * 0xFFFF.
        accept(32'h0001_0001, 32'h0000_FFFF);
        wait_done("mid", 64'h0000_0000_FFFF_FFFF, ET ? 16 : 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_seq_32.md
# mult_seq_32

Sequential 32×32 unsigned shift-and-add multiplier for the CPU's execute stage. It accepts operands on a start pulse and instantiates `adder_32bit` for the partial-sum add in each iteration. The 64-bit product is returned after a fixed number of iterations, or fewer when the early-termination option is compiled in. The ALU issues `start` and consumes `product` on `done`.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 64-bit product.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `start` input 1: request a multiply; sampled only in IDLE or DONE.
- `a` input 32: multiplicand; latched when start is accepted.
- `b` input 32: multiplier; latched when start is accepted.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; product valid.
- `product` output 64: registered result; holds until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DONE on the finishing iteration.
  - DONE to RUN if `start` is high; otherwise DONE to IDLE.
- Internal registers:
  - `mcand[31:0]`.
  - `P[64:0]`: upper half is the accumulator, lower half is the multiplier bits not yet consumed.
  - `cnt[5:0]`.
- On accept: `mcand`=a, `P`={33'b0, b}, `cnt`=0.
- Each RUN edge performs one iteration:
  - If `P[0]`: {c, s} = `adder_32bit`(P[63:32], mcand, c0=0), else {c, s} = {0, P[63:32]}.
  - P ← {1'b0, c, s, P[31:1]}.
  - cnt ← cnt+1.
- Carry out of the add is captured in the shifted-in bit, so no overflow is lost. The result is exact modulo 2^64, which is the full unsigned product.
- Finishing iteration: `cnt` becomes 32. With early termination compiled in, it also finishes when the unconsumed multiplier bits are zero (see Configuration).
- On the finishing edge:
  - `product` ← the 64-bit result, right-aligned by (32−cnt_new) positions.
  - `done` is asserted.
- `start` while `busy` is ignored. No queueing; operands are not re-latched.
- `a`/`b` changes after acceptance have no effect.
- Reset (any time, including mid-RUN):
  - State goes to IDLE immediately.
  - busy=0, done=0, product=0, P=0, cnt=0.
  - An in-flight operation is discarded with no `done`.

## Timing
- Reset values: busy=0, done=0, product=64'h0.
- Start sampled high at edge N in IDLE:
  - busy=1 from after N.
  - Iterations occur on edges N+1 onward.
- Full latency (no early termination): done=1 and product valid in the cycle after edge N+32. busy=0 in that same cycle.
- `done` is high for exactly one cycle.
- Back-to-back: start high during the DONE cycle is accepted at that edge. busy returns high the next cycle with no idle gap.
- `product` changes only on a finishing edge or on reset.

## Configuration
- Macro: `MULT_EARLY_TERM_EN`.
- Defined:
  - After each iteration, if the unconsumed multiplier bits P[31−cnt_new:0]… are all zero, that iteration finishes.
  - Equivalently, it finishes when (b >> cnt_new) == 0.
  - The result is right-shifted by the remaining (32−cnt_new) positions, realised as a barrel shift on `P[63:0]`.
  - Latency: done after edge N+1+k, where k is the index of the highest set bit of b; k=0 for b=0 or b=1.
- Undefined: always exactly 32 iterations. No barrel shifter is synthesised, and the finishing shift is 0.

## Test plan
- Basic product: reset, then a=3, b=5, start at edge N.
  - product=64'h0F.
  - Without the macro: done after edge N+32, busy high for 32 cycles.
  - With the macro: done after N+3.
- Maximum operands: a=b=32'hFFFFFFFF → product=64'hFFFFFFFE_00000001. With the macro, latency is still 32 iterations because k=31.
- Busy ignores start: start a=7, b=9; re-pulse start with a=1, b=1 at N+10.
  - Result is 64'h3F.
  - Exactly one done pulse.
- Reset mid-operation: start a=b=32'h12345678; drop rst_n at N+15 asynchronously (between edges).
  - busy, done and product go 0 immediately.
  - No done follows.
  - A new start a=2, b=2 yields product=4.
- Early termination (macro defined):
  - b=0, a=32'hDEAD: done after N+1, product=0.
  - b=32'h80000000, a=2: done after N+32, product=64'h1_00000000.
- Back-to-back: assert start with a=10, b=10 in the DONE cycle of a prior operation.
  - Prior product is seen for one cycle.
  - busy rises the next cycle.
  - New product=64'd100.
